// File: rtl/myip_test_v1_0_s00_axis_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream byte-packing front end.
// Default widths, byte-count helpers and the two-state control enum.
package myip_test_v1_0_s00_axis_pkg;

    localparam int DEF_TDATA_WIDTH = 24;
    localparam int DEF_FIFO_WIDTH  = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

    // Worst case held bytes: one short of a word plus a whole incoming beat.
    function automatic int acc_bytes(input int in_bytes, input int out_bytes);
        return out_bytes - 1 + in_bytes;
    endfunction

endpackage

// File: rtl/axis_keep_compactor.sv
// Packs TKEEP-qualified bytes LSB-first with no gaps and reports how many were kept.
// Latency: purely combinational.
// Backpressure: none, no state.
module axis_keep_compactor #(
    parameter int IN_BYTES = 3,
    parameter int CNT_W    = 2
) (
    input  logic [IN_BYTES*8-1:0] data,
    input  logic [IN_BYTES-1:0]   keep,
    output logic [IN_BYTES*8-1:0] packed_dat,
    output logic [CNT_W-1:0]      kept_cnt
);

    always_comb begin
        packed_dat = '0;
        kept_cnt   = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (keep[k]) begin
                packed_dat[{kept_cnt, 3'b000} +: 8] = data[k*8 +: 8];
                kept_cnt = kept_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/myip_test_v1_0_s00_axis.sv
// AXI4-Stream slave packing kept bytes into FIFO words; TLAST flushes a zero-padded tail.
// Latency: word appears on fifo_write one cycle after the completing beat; split TLAST tail one cycle later.
// Backpressure: TREADY = !full in RUN, 0 in FLUSH and during reset.
module myip_test_v1_0_s00_axis
    import myip_test_v1_0_s00_axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int FIFO_DATA_WIDTH      = DEF_FIFO_WIDTH
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                              S_AXIS_TLAST,
    input  logic                              full,
    input  logic                              empty,
    output logic                              fifo_write,
    output logic [FIFO_DATA_WIDTH-1:0]        fifo_data_out
);

    localparam int IB     = bytes_of(C_S_AXIS_TDATA_WIDTH);
    localparam int OB     = bytes_of(FIFO_DATA_WIDTH);
    localparam int AB     = acc_bytes(IB, OB);
    localparam int ACC_W  = AB * 8;
    localparam int CNT_W  = $clog2(AB + 1);
    localparam int KCNT_W = $clog2(IB + 1);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OB);

    state_t                       state_q, state_d;
    logic [ACC_W-1:0]             acc_q, acc_d, merged, spill;
    logic [CNT_W-1:0]             cnt_q, cnt_d, total, spill_cnt;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] packed_dat;
    logic [KCNT_W-1:0]            kept_cnt;
    logic                         beat_acc;
    logic                         wr_d;
    logic [FIFO_DATA_WIDTH-1:0]   dat_d;
    logic                         unused_ok;

    assign unused_ok = empty;

    axis_keep_compactor #(
        .IN_BYTES (IB),
        .CNT_W    (KCNT_W)
    ) u_compactor (
        .data       (S_AXIS_TDATA),
        .keep       (S_AXIS_TKEEP),
        .packed_dat (packed_dat),
        .kept_cnt   (kept_cnt)
    );

    assign S_AXIS_TREADY = S_AXIS_ARESETN && (state_q == ST_RUN) && !full;
    assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;

    // Bytes above cnt_q are always zero, so OR-ing the new bytes in is safe.
    assign merged    = acc_q | (ACC_W'(packed_dat) << {cnt_q, 3'b000});
    assign total     = cnt_q + CNT_W'(kept_cnt);
    assign spill     = merged >> FIFO_DATA_WIDTH;
    assign spill_cnt = total - OUT_CNT;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        dat_d   = fifo_data_out;
        if (state_q == ST_RUN) begin
            if (beat_acc) begin
                if (total >= OUT_CNT) begin
                    wr_d  = 1'b1;
                    dat_d = merged[FIFO_DATA_WIDTH-1:0];
                    acc_d = spill;
                    cnt_d = spill_cnt;
                    if (S_AXIS_TLAST && (spill_cnt != '0)) begin
                        state_d = ST_FLUSH;
                    end else if (S_AXIS_TLAST) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end else if (S_AXIS_TLAST) begin
                    wr_d  = (total != '0);
                    dat_d = (total != '0) ? merged[FIFO_DATA_WIDTH-1:0] : fifo_data_out;
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = merged;
                    cnt_d = total;
                end
            end
        end else begin
            // Tail of a TLAST beat that also completed a word.
            if (!full) begin
                wr_d    = 1'b1;
                dat_d   = acc_q[FIFO_DATA_WIDTH-1:0];
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state_q       <= ST_RUN;
            acc_q         <= '0;
            cnt_q         <= '0;
            fifo_write    <= 1'b0;
            fifo_data_out <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            fifo_write    <= wr_d;
            fifo_data_out <= dat_d;
        end
    end

endmodule

// File: tb/tb_myip_test_v1_0_s00_axis.sv
// Scoreboard bench: byte-queue reference model feeds expected words, a negedge monitor checks writes.
module tb_myip_test_v1_0_s00_axis;

    localparam int TW = 24;
    localparam int FW = 32;
    localparam int IB = TW / 8;
    localparam int OB = FW / 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [TW-1:0] tdata = '0;
    logic [IB-1:0] tkeep = '0;
    logic          tlast = 1'b0;
    logic          full = 1'b0;
    logic          empty = 1'b0;
    logic          fifo_write;
    logic [FW-1:0] fifo_data_out;

    int ntests = 0;
    int nfail  = 0;
    logic [7:0]    byte_q[$];
    logic [FW-1:0] exp_q[$];
    logic          prev_full = 1'b0;
    logic          rand_full = 1'b0;

    myip_test_v1_0_s00_axis #(
        .C_S_AXIS_TDATA_WIDTH (TW),
        .FIFO_DATA_WIDTH      (FW)
    ) dut (
        .S_AXIS_ACLK    (aclk),
        .S_AXIS_ARESETN (aresetn),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TREADY  (tready),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TKEEP   (tkeep),
        .S_AXIS_TLAST   (tlast),
        .full           (full),
        .empty          (empty),
        .fifo_write     (fifo_write),
        .fifo_data_out  (fifo_data_out)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a packet is a byte stream, cut into OB-byte words, tail zero-padded on TLAST.
    function automatic logic [FW-1:0] pop_word(input int n);
        logic [FW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i*8 +: 8] = byte_q.pop_front();
        return w;
    endfunction

    task automatic model_beat(input logic [TW-1:0] d, input logic [IB-1:0] k, input logic l);
        for (int i = 0; i < IB; i++)
            if (k[i]) byte_q.push_back(d[i*8 +: 8]);
        while (byte_q.size() >= OB) exp_q.push_back(pop_word(OB));
        if (l && byte_q.size() > 0) exp_q.push_back(pop_word(byte_q.size()));
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
        if (rand_full) full = ($urandom_range(3) == 0);
    endtask

    task automatic send_beat(input logic [TW-1:0] d, input logic [IB-1:0] k, input logic l);
        int n;
        n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        forever begin
            #1;
            if (tready === 1'b1) begin
                model_beat(d, k, l);
                tick();
                break;
            end
            tick();
            n++;
            if (n > 300) begin
                ntests++;
                nfail++;
                $display("FAIL beat_accept_timeout: tready stuck at %0b, expected 1", tready);
                break;
            end
        end
        tvalid = 1'b0;
    endtask

    task automatic drain_check(input string name);
        tvalid = 1'b0;
        repeat (6) tick();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // A beat held valid during reset must not be taken; leftover bytes are dropped.
    task automatic do_reset();
        aresetn = 1'b0;
        tvalid  = 1'b1;
        tdata   = 24'hEEEEEE;
        tkeep   = 3'b111;
        tlast   = 1'b0;
        #1;
        check("tready_during_reset", 64'(tready), 64'd0);
        byte_q.delete();
        tick();
        #1;
        check("reset_fifo_write", 64'(fifo_write), 64'd0);
        check("reset_fifo_data_out", 64'(fifo_data_out), 64'd0);
        check("reset_tready", 64'(tready), 64'd0);
        tvalid  = 1'b0;
        aresetn = 1'b1;
        #1;
        check("tready_after_release", 64'(tready), 64'd1);
        tick();
    endtask

    initial begin : monitor
        logic [FW-1:0] w;
        forever begin
            @(negedge aclk);
            if (fifo_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write", fifo_data_out);
                end else begin
                    w = exp_q.pop_front();
                    check("fifo_data_out", 64'(fifo_data_out), 64'(w));
                    check("write_while_full", 64'(prev_full), 64'd0);
                end
            end
            prev_full = full;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [TW-1:0] d;
        logic [IB-1:0] k;
        logic          l;

        tick();
        do_reset();

        // Full beats, four beats -> three words.
        send_beat(24'h030201, 3'b111, 1'b0);
        send_beat(24'h060504, 3'b111, 1'b0);
        send_beat(24'h090807, 3'b111, 1'b0);
        send_beat(24'h0C0B0A, 3'b111, 1'b1);
        drain_check("full_beats_drain");

        // Sparse keep.
        send_beat(24'hCCBBAA, 3'b101, 1'b0);
        send_beat(24'hFFEEDD, 3'b010, 1'b1);
        drain_check("sparse_drain");

        // TLAST producing a word plus a tail.
        send_beat(24'h030201, 3'b111, 1'b0);
        send_beat(24'h060504, 3'b111, 1'b1);
        #1;
        check("flush_tready_low", 64'(tready), 64'd0);
        tick();
        #1;
        check("flush_tready_back", 64'(tready), 64'd1);
        tick();
        send_beat(24'h0A0908, 3'b111, 1'b1);
        drain_check("overflow_drain");

        // Back-pressure mid-packet.
        send_beat(24'h030201, 3'b111, 1'b0);
        send_beat(24'h060504, 3'b111, 1'b0);
        send_beat(24'h090807, 3'b111, 1'b0);
        full   = 1'b1;
        tvalid = 1'b1;
        tdata  = 24'h0C0B0A;
        tkeep  = 3'b111;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_tready", 64'(tready), 64'd0);
            check("stall_no_write", 64'(fifo_write), 64'd0);
            tick();
        end
        full = 1'b0;
        send_beat(24'h0C0B0A, 3'b111, 1'b0);
        send_beat(24'h0F0E0D, 3'b111, 1'b0);
        send_beat(24'h121110, 3'b111, 1'b1);
        drain_check("backpressure_drain");

        // Reset mid-packet.
        send_beat(24'h030201, 3'b111, 1'b0);
        do_reset();
        send_beat(24'h0C0B0A, 3'b111, 1'b0);
        send_beat(24'h000D00, 3'b010, 1'b1);
        drain_check("reset_mid_packet_drain");

        // Randomised traffic with random stalls and zero-keep beats.
        rand_full = 1'b1;
        for (int i = 0; i < 400; i++) begin
            d = TW'($urandom);
            k = IB'($urandom_range((1 << IB) - 1));
            l = (i == 399) || ($urandom_range(5) == 0);
            if ($urandom_range(4) == 0) tick();
            send_beat(d, k, l);
        end
        rand_full = 1'b0;
        full      = 1'b0;
        drain_check("random_drain");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
